soc_system_pio_poller: RTL and testbench

SOC_SYSTEM_PIO_POLLER -- requirements
Module: soc_system_pio_poller

---
 rtl/soc_system_pio_poller.sv | 169 ++++++++++++++++
 tb/tb_soc_system_pio_poller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_poller.sv
// Periodic Avalon-MM reader of a PIO slave feeding a first-word-fall-through sample FIFO.
// Optional change filter: define SOC_SYSTEM_PIO_POLLER_CHANGE_FILTER_EN to push only changed samples.
//   state    | meaning
//   ST_IDLE  | count enabled cycles until the next read is due
//   ST_ISSUE | drive the one-cycle read strobe
//   ST_WAIT  | readdata valid this cycle; capture and push at its end
module soc_system_pio_poller #(
  parameter int unsigned POLL_DIV   = 1000,
  parameter int unsigned DATA_W     = 19,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        m_address,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  output logic              smp_valid,
  output logic [DATA_W-1:0] smp_data,
  input  logic              smp_ready,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0]   CNT_TC  = 16'(POLL_DIV - 3);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  generate
    if (POLL_DIV < 3 || POLL_DIV > 65535) begin : g_bad_div
      $error("POLL_DIV must be within 3..65535");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two within 2..16");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
      $error("DATA_W must be within 1..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // IDLE spends POLL_DIV-2 enabled cycles, so ISSUE+WAIT close the POLL_DIV period.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    m_read   = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!enable) begin
          cnt_nx = '0;
        end else if (cnt == CNT_TC) begin
          state_nx = ST_ISSUE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      ST_ISSUE: begin
        m_read   = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        capture  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign m_address = 2'b00;

  logic [DATA_W-1:0] sample;
  logic              push;

  assign sample = m_readdata[DATA_W-1:0];

  generate
    if (DATA_W < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^m_readdata[31:DATA_W];
    end
  endgenerate

`ifdef SOC_SYSTEM_PIO_POLLER_CHANGE_FILTER_EN
  logic [DATA_W-1:0] ref_data;
  logic              ref_valid;

  // Reference tracks every capture, including ones the FIFO drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_data  <= '0;
      ref_valid <= 1'b0;
    end else if (capture) begin
      ref_data  <= sample;
      ref_valid <= 1'b1;
    end
  end

  assign push = capture && (!ref_valid || (sample != ref_data));
`else
  assign push = capture;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty, pop, wr_en, drop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign pop   = !empty && smp_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample;
  end

  // Head is forced to zero when empty so the output is defined straight out of reset.
  assign smp_valid = !empty;
  assign smp_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_soc_system_pio_poller.sv
// Directed bench for soc_system_pio_poller: a spec-level model (cycle credits + sample queue)
// is compared on every falling edge, and each scenario also pins hand-computed literals.
module tb_soc_system_pio_poller;
  localparam int PD = 10;
  localparam int DW = 19;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    m_address;
  logic          m_read;
  logic [31:0]   m_readdata = 32'h0;
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic          smp_ready = 1'b0;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  soc_system_pio_poller #(.POLL_DIV(PD), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave: registered readdata, latency 1, values taken from a per-poll table.
  logic [31:0] tab [8];
  int idx = 0;
  always @(posedge clk) begin
    if (reset) idx <= 0;
    else if (m_read) begin
      m_readdata <= tab[idx % 8];
      idx <= idx + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: busy counts the read in flight (2 = strobe cycle, 1 = data cycle);
  // credit counts consecutive enabled idle cycles; q is the FIFO contents.
  int            busy = 0;
  int            credit = 0;
  logic [DW-1:0] q [$];
  bit            m_ovf = 1'b0;
  bit            ref_ok = 1'b0;
  logic [DW-1:0] ref_v = '0;
  logic [DW-1:0] s;
  bit            mpop, was_full, want, ovf_set;
  int            pop_count = 0;
  logic [DW-1:0] pop_first = '0, pop_last = '0;

  always @(negedge clk) begin
    chk("m_read", {31'h0, m_read}, {31'h0, busy == 2});
    chk("m_address", {30'h0, m_address}, 32'h0);
    chk("smp_valid", {31'h0, smp_valid}, {31'h0, q.size() != 0});
    chk("smp_data", {{(32-DW){1'b0}}, smp_data}, (q.size() != 0) ? {{(32-DW){1'b0}}, q[0]} : 32'h0);
    chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    if (reset) begin
      busy = 0; credit = 0; q.delete(); m_ovf = 1'b0; ref_ok = 1'b0; pop_count = 0;
    end else begin
      if (smp_valid && smp_ready) begin
        if (pop_count == 0) pop_first = smp_data;
        pop_last = smp_data;
        pop_count++;
      end
      mpop = (q.size() != 0) && smp_ready;
      was_full = (q.size() == FD);
      ovf_set = 1'b0;
      if (mpop) void'(q.pop_front());
      if (busy == 1) begin
        s = m_readdata[DW-1:0];
        want = 1'b1;
`ifdef SOC_SYSTEM_PIO_POLLER_CHANGE_FILTER_EN
        want = !ref_ok || (s != ref_v);
        ref_ok = 1'b1;
        ref_v = s;
`endif
        if (want) begin
          if (was_full && !mpop) ovf_set = 1'b1;
          else q.push_back(s);
        end
      end
      if (busy > 0) busy--;
      else if (enable) begin
        credit++;
        if (credit == PD - 2) begin busy = 2; credit = 0; end
      end else credit = 0;
      if (ovf_set) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; smp_ready = 1'b0; overflow_clr = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_mread(output int at);
    int n = 0;
    do begin step(); n++; end while (!m_read && n < 40);
    chk("wait_mread", {31'h0, m_read}, 32'h1);
    at = cyc;
  endtask

  task automatic drain(input logic [DW-1:0] v0, v1, v2, v3);
    logic [DW-1:0] e [4];
    e[0] = v0; e[1] = v1; e[2] = v2; e[3] = v3;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", {{(32-DW){1'b0}}, smp_data}, {{(32-DW){1'b0}}, e[i]});
      smp_ready = 1'b1; step(); smp_ready = 1'b0;
    end
    chk("drain_empty", {31'h0, smp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;

    // Period, strobe width, first-sample latency, high readdata bits ignored.
    for (int i = 0; i < 8; i++) tab[i] = 32'hFFF5_A5A3;
    do_reset();
    enable = 1'b1; smp_ready = 1'b1; t0 = cyc;
    wait_mread(t1);
    chk("first_issue", t1 - t0, 8);
    step();
    chk("strobe_width", {31'h0, m_read}, 32'h0);
    step();
    chk("first_valid", {31'h0, smp_valid}, 32'h1);
    chk("first_data", {{(32-DW){1'b0}}, smp_data}, 32'h5A5A3);
    wait_mread(t2);
    chk("period_a", t2 - t1, 10);
    wait_mread(t3);
    chk("period_b", t3 - t2, 10);

    // Overflow on the fifth push, set beats clear on the sixth, then clear and drain.
    tab[0] = 32'hABC0_0011; tab[1] = 32'h0000_0022; tab[2] = 32'h8000_0033;
    tab[3] = 32'h0000_0044; tab[4] = 32'h0000_0055; tab[5] = 32'h0000_0066;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) wait_mread(t1);
    step(); step();
    chk("ovf_after5", {31'h0, overflow}, 32'h1);
    chk("head_after5", {{(32-DW){1'b0}}, smp_data}, 32'h11);
    wait_mread(t1);
    enable = 1'b0;
    step(); overflow_clr = 1'b1;
    step(); overflow_clr = 1'b0;
    chk("ovf_set_wins", {31'h0, overflow}, 32'h1);
    repeat (25) step();
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);
    drain(19'h11, 19'h22, 19'h33, 19'h44);

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 5; i++) tab[i] = 32'h101 + i;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) wait_mread(t1);
    wait_mread(t1);
    enable = 1'b0;
    step(); smp_ready = 1'b1;
    step(); smp_ready = 1'b0;
    chk("full_pushpop_ovf", {31'h0, overflow}, 32'h0);
    drain(19'h102, 19'h103, 19'h104, 19'h105);

    // Constant readdata then a change.
    for (int i = 0; i < 5; i++) tab[i] = 32'h123;
    tab[5] = 32'h124;
    do_reset();
    enable = 1'b1; smp_ready = 1'b1;
    for (int i = 0; i < 6; i++) wait_mread(t1);
    enable = 1'b0;
    step(); step(); step();
`ifdef SOC_SYSTEM_PIO_POLLER_CHANGE_FILTER_EN
    chk("filter_count", pop_count, 2);
`else
    chk("filter_count", pop_count, 6);
`endif
    chk("filter_first", {{(32-DW){1'b0}}, pop_first}, 32'h123);
    chk("filter_last", {{(32-DW){1'b0}}, pop_last}, 32'h124);

    // Reset during the data cycle aborts the capture.
    tab[0] = 32'h7; tab[1] = 32'h7;
    do_reset();
    enable = 1'b1;
    wait_mread(t1);
    step(); reset = 1'b1;
    step(); reset = 1'b0; t2 = cyc;
    chk("abort_no_push", {31'h0, smp_valid}, 32'h0);
    wait_mread(t3);
    chk("abort_gap_issue", t3 - t1, 10);
    chk("abort_gap_release", t3 - t2, 8);
    step(); step();
    chk("after_abort_push", {31'h0, smp_valid}, 32'h1);

    // Enable gap restarts the interval count.
    do_reset();
    enable = 1'b1; repeat (3) step();
    enable = 1'b0; repeat (5) step();
    enable = 1'b1; t0 = cyc;
    wait_mread(t1);
    chk("reenable_latency", t1 - t0, 8);
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
